dec_round_iter: RTL and testbench



---
 rtl/dec_round_iter.sv | 207 ++++++++++++++++++++
 tb/tb_dec_round_iter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_round_iter.sv
`default_nettype none
// ============================================================================
// Module   : dec_round_iter
// Purpose  : Iterative AES-128 decryption engine (inverse cipher, rounds
//            10..0) built around one shared round datapath.  Each round
//            takes two clocks:
//              SUB  InvShiftRows + InvSubBytes into the S-box stage register
//              KEY  AddRoundKey (+ InvMixColumns except in the last round)
//            Round keys come from an external combinational key store that
//            is addressed through rkey_idx.
// Ports    : clk, rst_n       clock / asynchronous active-low reset
//            in_valid/in_ready/din    ciphertext input handshake (128 bit)
//            rkey_idx/rkey            round-key fetch (index 0..10, key back
//                                     combinationally in the same cycle)
//            out_valid/out_ready/dout plaintext output handshake (128 bit)
//            flush                    only with DEC_ROUND_ITER_FLUSH_EN:
//                                     synchronous abort back to IDLE
// Options  : `define DEC_ROUND_ITER_FLUSH_EN to add the flush input.
// Byte map : bit 127 = s(0,0); byte k = s(k%4, k/4) (column-major).
// Revision : 1.0  initial release
// ============================================================================
module dec_round_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   rkey_idx,
  input  logic [127:0] rkey,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef DEC_ROUND_ITER_FLUSH_EN
  input  logic         flush,
`endif
  output logic [127:0] dout
);

  localparam logic [3:0] C_FIRST_IDX = 4'(NR);
  localparam logic [3:0] C_LAST_RND  = 4'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_KEY  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Row r rotates right by r: s'(r,c) = s(r,(c-r) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int r;
    int c;
    int src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = r + 4 * ((c + 4 - r) % 4);
      o[127 - 8*k -: 8] = s[127 - 8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c      -: 8];
      a1 = s[127 - 32*c - 8  -: 8];
      a2 = s[127 - 32*c - 16 -: 8];
      a3 = s[127 - 32*c - 24 -: 8];
      o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------- registers
  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_sub;    // S-box stage output, consumed in KEY
  logic [127:0] w_t;      // add_rkey result of the current round
  logic         w_flush;

`ifdef DEC_ROUND_ITER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_sub   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      // The S-box stage free-runs; only the value captured on the SUB->KEY
      // edge is ever used.
      r_sub   <= inv_sub_bytes(inv_shift_rows(r_state));
    end
  end

  // ---------------------------------------------------------------- control
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rkey_idx    = r_round;
    w_t         = r_sub ^ rkey;

    case (r_fsm)
      S_IDLE: begin
        in_ready = ~w_flush;
        rkey_idx = C_FIRST_IDX;
        if (in_valid && !w_flush) begin
          w_state_nxt = din ^ rkey;
          w_round_nxt = C_LAST_RND;
          w_fsm_nxt   = S_SUB;
        end
      end
      S_SUB: begin
        w_fsm_nxt = S_KEY;
      end
      S_KEY: begin
        if (r_round != 4'd0) begin
          w_state_nxt = inv_mix_columns(w_t);
          w_round_nxt = r_round - 4'd1;
          w_fsm_nxt   = S_SUB;
        end else begin
          // Final round carries no InvMixColumns.
          w_state_nxt = w_t;
          w_fsm_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        rkey_idx  = 4'd0;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase

    // Flush wins over everything but leaves the state register untouched.
    if (w_flush) begin
      w_fsm_nxt   = S_IDLE;
      w_round_nxt = 4'd0;
    end
  end

  assign dout = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dec_round_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_round_iter
// Purpose  : Self-checking bench for dec_round_iter.  Keeps a byte-level AES
//            inverse-cipher model plus a cycle-age model of the handshake
//            timing, and compares DUT outputs every cycle on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_dec_round_iter;

  localparam logic [127:0] C_KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] din = '0;
  logic [3:0]   rkey_idx;
  logic [127:0] rkey;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] dout;
`ifdef DEC_ROUND_ITER_FLUSH_EN
  logic         flush = 1'b0;
`endif

  logic [127:0] ks [0:10];
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  logic [127:0] last_pt = '0;

  assign rkey = (rkey_idx <= 4'd10) ? ks[rkey_idx] : '0;

  always #5 clk = ~clk;

  dec_round_iter #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .rkey_idx (rkey_idx),
    .rkey     (rkey),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef DEC_ROUND_ITER_FLUSH_EN
    .flush    (flush),
`endif
    .dout     (dout)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- AES model
  // Carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    logic [7:0] s;
    int inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = y;
      b = 8'(inv);
      s = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8*k -: 8] ^ ks[10][127 - 8*k -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*c] = isbox_t[s[r + 4*((c - r + 4) % 4)]];
      for (int k = 0; k < 16; k++) t[k] = t[k] ^ ks[rnd][127 - 8*k -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c + r] = m_mul(8'h0e, t[4*c + r]) ^ m_mul(8'h0b, t[4*c + (r+1)%4]) ^
                         m_mul(8'h0d, t[4*c + (r+2)%4]) ^ m_mul(8'h09, t[4*c + (r+3)%4]);
      end else begin
        s = t;
      end
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = s[k];
    return o;
  endfunction

  // ---------------------------------------------------------------- monitor
  // m_age = clock edges since the accepting edge; 0..19 = rounds, >=20 = done.
  initial begin : monitor
    bit           m_busy;
    int           m_age;
    logic [127:0] m_exp;
    logic         fl;
    logic         exp_ir, exp_ov;
    int           exp_idx;
    m_busy = 0;
    m_age  = 0;
    m_exp  = '0;
    forever begin
      @(negedge clk);
`ifdef DEC_ROUND_ITER_FLUSH_EN
      fl = flush;
`else
      fl = 1'b0;
`endif
      if (!rst_n) begin
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_dout",      dout,            128'd0);
        chk("rst_rkey_idx",  128'(rkey_idx),  128'd10);
        m_busy = 0;
      end else begin
        exp_ir  = !m_busy && !fl;
        exp_ov  = m_busy && (m_age >= 20);
        exp_idx = !m_busy ? 10 : (m_age >= 20 ? 0 : 9 - m_age / 2);
        chk("in_ready",  128'(in_ready),  128'(exp_ir));
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        chk("rkey_idx",  128'(rkey_idx),  128'(exp_idx));
        if (exp_ov) chk("dout", dout, m_exp);
        if (in_valid && in_ready) n_acc++;
        if (out_valid && out_ready) begin
          last_pt = dout;
          n_out++;
        end
        if (fl) begin
          m_busy = 0;
        end else if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1;
            m_age  = 0;
            m_exp  = model_dec(din);
          end
        end else if (m_age >= 20) begin
          if (out_ready) m_busy = 0;
        end else begin
          m_age++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic send(input logic [127:0] ct, input bit keep);
    int start;
    int t;
    start    = n_acc;
    t        = 0;
    din      = ct;
    in_valid = 1'b1;
    while (n_acc == start && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (n_acc == start) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, input bit rnd_ready);
    int t;
    t = 0;
    while (n_out < target && t < budget) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    if (n_out < target) begin
      n_chk++; n_err++;
      $display("FAIL output_timeout: got %0d outputs expected %0d", n_out, target);
    end
  endtask

  initial begin : driver
    int tgt;
    int acc0;
    int t;
    logic [127:0] key;
    logic [127:0] ct;
    for (int r = 0; r <= 10; r++) ks[r] = '0;
    build_tables();

    // Model pinned to published vectors (round-10 keys and plaintexts).
    load_key(C_KEY_A);
    chk("model_rk10_a", ks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_pt_a", model_dec(C_CT_A), C_PT_A);
    load_key(C_KEY_B);
    chk("model_rk10_b", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_pt_b", model_dec(C_CT_B), C_PT_B);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tgt = 0;

    // C.1 with out_ready already high before DONE.
    load_key(C_KEY_A);
    out_ready = 1'b1;
    send(C_CT_A, 1'b0);
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("c1_plaintext", last_pt, C_PT_A);

    // Appendix B.
    load_key(C_KEY_B);
    send(C_CT_B, 1'b0);
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("appb_plaintext", last_pt, C_PT_B);

    // Backpressure: hold 50 cycles once out_valid rises.
    load_key(C_KEY_A);
    out_ready = 1'b0;
    send(C_CT_A, 1'b0);
    t = 0;
    while (!out_valid && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_out_valid_seen", 128'(out_valid), 128'd1);
    repeat (50) @(posedge clk);
    #1 out_ready = 1'b1;
    tgt++; wait_out(tgt, 10, 1'b0);
    chk("bp_plaintext", last_pt, C_PT_A);

    // Back-to-back with in_valid held high through the busy period.
    load_key(C_KEY_A);
    send(C_CT_A, 1'b1);
    din  = C_CT_B;
    acc0 = n_acc;
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("b2b_first", last_pt, C_PT_A);
    chk("b2b_no_busy_accept", 128'(n_acc), 128'(acc0));
    load_key(C_KEY_B);
    t = 0;
    while (n_acc == acc0 && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("b2b_second", last_pt, C_PT_B);

    // Reset in the middle of a block.
    load_key(C_KEY_A);
    send(C_CT_A, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_no_output", 128'(n_out), 128'(tgt));
    send(C_CT_A, 1'b0);
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("post_rst_plaintext", last_pt, C_PT_A);

`ifdef DEC_ROUND_ITER_FLUSH_EN
    // Flush mid-block, then flush coincident with in_valid in IDLE.
    send(C_CT_A, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (25) @(posedge clk);
    #1 chk("flush_no_output", 128'(n_out), 128'(tgt));
    acc0     = n_acc;
    flush    = 1'b1;
    in_valid = 1'b1;
    din      = C_CT_B;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_blocks_accept", 128'(n_acc), 128'(acc0));
    load_key(C_KEY_B);
    send(C_CT_B, 1'b0);
    tgt++; wait_out(tgt, 60, 1'b0);
    chk("post_flush_plaintext", last_pt, C_PT_B);
`endif

    // Randomised keys, ciphertexts, idle gaps and output backpressure.
    for (int i = 0; i < 8; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 send(ct, 1'b0);
      tgt++; wait_out(tgt, 300, 1'b1);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
